// File: rtl/util_led_pkg.sv
// ----------------------------------------------------------------------------
// util_led_pkg
//   Shared definitions for the LED blink driver / decoder pair.
//   - MODE_*  : {blink, state} mode codes used on both sides of the link.
//   - ST_*    : decoder FSM state constants.
//   - CLS_*   : phase-length classification results.
//   - in_window / classify_len : phase-length helpers, evaluated at 34 bits
//     so no term of the tolerance comparison can wrap or truncate.
// ----------------------------------------------------------------------------
package util_led_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_ON   = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;
  localparam logic [1:0] MODE_SLOW = 2'b11;

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_STEADY  = 2'd1;
  localparam logic [1:0] ST_BLINK   = 2'd2;

  localparam logic [1:0] CLS_NONE  = 2'd0;
  localparam logic [1:0] CLS_SHORT = 2'd1;
  localparam logic [1:0] CLS_LONG  = 2'd2;
  localparam logic [1:0] CLS_BAD   = 2'd3;

  // |len - nom| <= tol, rewritten as two additions so nothing goes negative.
  function automatic logic in_window(input logic [31:0] len,
                                     input int unsigned nom,
                                     input int unsigned tol);
    logic [33:0] len_w;
    logic [33:0] nom_w;
    logic [33:0] tol_w;
    len_w = {2'b00, len};
    nom_w = 34'(nom);
    tol_w = 34'(tol);
    return ((len_w + tol_w) >= nom_w) && (len_w <= (nom_w + tol_w));
  endfunction

  // LONG window is tested first; the windows are disjoint by construction.
  function automatic logic [1:0] classify_len(input logic [31:0] len,
                                              input int unsigned long_clks,
                                              input int unsigned short_clks,
                                              input int unsigned tol);
    logic [1:0] cls;
    if (in_window(len, long_clks, tol)) begin
      cls = CLS_LONG;
    end else if (in_window(len, short_clks, tol)) begin
      cls = CLS_SHORT;
    end else begin
      cls = CLS_BAD;
    end
    return cls;
  endfunction

endpackage

// File: rtl/util_sync_bit.sv
// ----------------------------------------------------------------------------
// util_sync_bit
//   Multi-flop synchronizer for one asynchronous bit.
//   Ports:
//     clk  in  clock
//     rst  in  synchronous active-high reset, loads RST_VAL into every stage
//     d_i  in  asynchronous input
//     q_o  out synchronized output (last stage)
// ----------------------------------------------------------------------------
module util_sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Shift chain: new sample enters at bit 0, leaves at the top bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/util_led_blink_decode.sv
// ----------------------------------------------------------------------------
// util_led_blink_decode
//   Decodes a 1-bit LED-style line back into the blink driver's
//   {blink, state} mode code (steady off/on, fast blink, slow blink).
//   Ports:
//     clk     in   clock
//     rst     in   synchronous active-high reset
//     led_in  in   asynchronous LED line
//     mode    out  decoded {blink, state}: 00 off, 01 on, 10 fast, 11 slow
//     valid   out  mode is locked
//     err     out  one-cycle pulse on a phase length outside both windows
// ----------------------------------------------------------------------------
module util_led_blink_decode
  import util_led_pkg::*;
#(
  parameter logic ACTIVE_LEVEL  = 1'b0,
  parameter int   INACTIVE_CLKS = 10,
  parameter int   ACTIVE_CLKS   = 20,
  parameter int   TOL_CLKS      = 2,
  parameter int   STEADY_CLKS   = 64,
  parameter int   SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_in,
  output logic [1:0] mode,
  output logic       valid,
  output logic       err
);

  localparam logic [31:0] STEADY_W = 32'(STEADY_CLKS);

  logic        sync_out;
  logic        act;
  logic        act_edge;
  logic        run_sat;
  logic [1:0]  cls;

  logic        act_q;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic [1:0]  state_q,   state_d;
  logic        armed_q,   armed_d;
  logic [1:0]  prior_q,   prior_d;
  logic [1:0]  mode_q,    mode_d;
  logic        valid_q,   valid_d;
  logic        err_q,     err_d;

  // Synchronizer idles at the inactive level so reset never looks like an edge.
  util_sync_bit #(
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (~ACTIVE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (led_in),
    .q_o (sync_out)
  );

  assign act      = (sync_out == ACTIVE_LEVEL);
  assign act_edge = act ^ act_q;
  // A saturated counter means the phase length is unknown; never classify it.
  assign run_sat  = (run_cnt_q >= STEADY_W);
  assign cls      = classify_len(run_cnt_q, ACTIVE_CLKS, INACTIVE_CLKS, TOL_CLKS);

  // Next-state logic: phase counter plus ACQUIRE/STEADY/BLINK decoding.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    prior_d = prior_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    if (act_edge) begin
      run_cnt_d = 32'd1;
    end else if (run_sat) begin
      run_cnt_d = STEADY_W;
    end else begin
      run_cnt_d = run_cnt_q + 32'd1;
    end

    if (act_edge) begin
      if (run_sat || (state_q == ST_STEADY)) begin
        // Leaving a steady line: the phase just ended is not measurable.
        state_d = ST_ACQUIRE;
        valid_d = 1'b0;
        armed_d = 1'b1;
        prior_d = CLS_NONE;
      end else begin
        case (state_q)
          ST_ACQUIRE: begin
            if (!armed_q) begin
              // First edge only marks the start of a full phase.
              armed_d = 1'b1;
            end else if (cls == CLS_BAD) begin
              err_d   = 1'b1;
              prior_d = CLS_NONE;
            end else if (cls == prior_q) begin
              state_d = ST_BLINK;
              mode_d  = {1'b1, (cls == CLS_LONG)};
              valid_d = 1'b1;
              prior_d = CLS_NONE;
            end else begin
              prior_d = cls;
            end
          end
          ST_BLINK: begin
            if (cls == CLS_BAD) begin
              err_d   = 1'b1;
              valid_d = 1'b0;
              state_d = ST_ACQUIRE;
              armed_d = 1'b1;
              prior_d = CLS_NONE;
            end else if ((cls == CLS_LONG) == mode_q[0]) begin
              state_d = ST_BLINK;
            end else begin
              // Driver changed rate: reacquire, seeding with this phase.
              valid_d = 1'b0;
              state_d = ST_ACQUIRE;
              armed_d = 1'b1;
              prior_d = cls;
            end
          end
          default: begin
            state_d = ST_ACQUIRE;
            valid_d = 1'b0;
            armed_d = 1'b0;
            prior_d = CLS_NONE;
          end
        endcase
      end
    end else if (run_sat) begin
      state_d = ST_STEADY;
      mode_d  = {1'b0, act};
      valid_d = 1'b1;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q     <= 1'b0;
      run_cnt_q <= 32'd0;
      state_q   <= ST_ACQUIRE;
      armed_q   <= 1'b0;
      prior_q   <= CLS_NONE;
      mode_q    <= MODE_OFF;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      act_q     <= act;
      run_cnt_q <= run_cnt_d;
      state_q   <= state_d;
      armed_q   <= armed_d;
      prior_q   <= prior_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign mode  = mode_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule
